// File: rtl/hdmi_rd_sched.sv
// -----------------------------------------------------------------------------
// hdmi_rd_sched
//   Frame-read scheduler for the HDMI output path, running in the DDR user
//   clock domain. It refills the HDMI line buffer with one DDR burst read at a
//   time, and only while the buffer fill level is at or below LOW_WM. Frames
//   are double-buffered across two DDR banks: each frame start picks the bank
//   the writer completed most recently, or repeats the current bank when no
//   new frame has arrived. Every display frame sync restarts the frame at
//   burst 0.
//
// Optional build macro:
//   RD_TIMEOUT_EN - adds a watchdog that abandons the wait for user_rd_end
//                   after TIMEOUT cycles, sets timeout_err and returns to
//                   WAIT_SYNC. Without it, timeout_err is tied to 0.
//
// Ports:
//   sclk           DDR user clock (only clock)
//   rst            synchronous active-high reset
//   enable         scheduler runs while high
//   frame_sync     one-cycle display frame-start pulse
//   wr_frame_done  one-cycle pulse, writer finished a frame
//   wr_bank        bank the writer finished (valid with wr_frame_done)
//   fifo_wrcount   HDMI buffer write-side word count
//   rd_start       one-cycle burst request (high while in REQ)
//   rd_addr        burst start address, held until the next request
//   rd_len         burst length, constant BURST_LEN
//   user_rd_end    one-cycle pulse, burst complete
//   rd_data_valid  one pulse per returned 128-bit word
//   rd_bank        bank currently being read
//   busy           a burst is outstanding
//   len_err        sticky: a burst returned a word count other than BURST_LEN
//   resync_cnt     saturating count of mid-frame resyncs
//   timeout_err    sticky watchdog flag
// -----------------------------------------------------------------------------
module hdmi_rd_sched #(
  parameter int                ADDR_W       = 28,
  parameter int                BURST_LEN    = 64,
  parameter int                ADDR_INC     = 512,
  parameter int                FRAME_BURSTS = 3600,
  parameter logic [ADDR_W-1:0] BANK_BASE0   = '0,
  parameter logic [ADDR_W-1:0] BANK_BASE1   = 'h0100_0000,
  parameter int                FIFO_AW      = 10,
  parameter int                LOW_WM       = 256,
  parameter int                TIMEOUT      = 4096
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_sync,
  input  logic              wr_frame_done,
  input  logic              wr_bank,
  input  logic [FIFO_AW-1:0] fifo_wrcount,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              user_rd_end,
  input  logic              rd_data_valid,
  output logic              rd_bank,
  output logic              busy,
  output logic              len_err,
  output logic [7:0]        resync_cnt,
  output logic              timeout_err
);

  localparam int IDX_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int WC_W  = 9;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(FRAME_BURSTS - 1);
  localparam logic [WC_W:0]      BURST_CNT = (WC_W+1)'(BURST_LEN);
  localparam logic [FIFO_AW:0]   LOW_WM_V  = (FIFO_AW+1)'(LOW_WM);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SYNC = 3'd1,
    CHECK     = 3'd2,
    REQ       = 3'd3,
    WAIT_END  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              ready_bank_q, ready_bank_d;
  logic              new_frame_q, new_frame_d;
  logic [IDX_W-1:0]  burst_idx_q, burst_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_start_q, rd_start_d;
  logic              busy_q, busy_d;
  logic              len_err_q, len_err_d;
  logic [7:0]        resync_cnt_q, resync_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              pend_q, pend_d;
  logic              fifo_low_q;
  logic              take_bank;
  logic              sel_new;
  logic              sel_bank;
  logic              last_burst;
  logic [WC_W:0]     word_total;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [WC_W-1:0] sat_inc_wc(input logic [WC_W-1:0] v);
    return (v == {WC_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] burst_addr(input logic bank,
                                                   input logic [IDX_W-1:0] idx);
    return (bank ? BANK_BASE1 : BANK_BASE0) + ADDR_W'(idx) * ADDR_W'(ADDR_INC);
  endfunction

  // A wr_frame_done arriving in the same cycle as the bank is taken wins over
  // the previously recorded bank.
  assign sel_new    = new_frame_q | wr_frame_done;
  assign sel_bank   = wr_frame_done ? wr_bank : ready_bank_q;
  assign last_burst = (burst_idx_q == LAST_IDX);
  // A valid in the same cycle as user_rd_end still belongs to this burst.
  assign word_total = {1'b0, word_cnt_q} + {{WC_W{1'b0}}, rd_data_valid};

`ifdef RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    ready_bank_d = sel_bank;
    new_frame_d  = sel_new;
    burst_idx_d  = burst_idx_q;
    rd_bank_d    = rd_bank_q;
    rd_addr_d    = rd_addr_q;
    rd_start_d   = 1'b0;
    busy_d       = busy_q;
    len_err_d    = len_err_q;
    resync_cnt_d = resync_cnt_q;
    word_cnt_d   = word_cnt_q;
    pend_d       = pend_q;
    take_bank    = 1'b0;
`ifdef RD_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_SYNC;
      end

      WAIT_SYNC: begin
        if (frame_sync) begin
          take_bank = 1'b1;
          state_d   = CHECK;
        end
      end

      CHECK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (frame_sync) begin
          // Mid-frame sync: restart the frame right away.
          take_bank    = 1'b1;
          resync_cnt_d = sat_inc8(resync_cnt_q);
        end else if (fifo_low_q) begin
          state_d    = REQ;
          rd_start_d = 1'b1;
          rd_addr_d  = burst_addr(rd_bank_q, burst_idx_q);
        end
      end

      REQ: begin
        busy_d     = 1'b1;
        word_cnt_d = '0;
        state_d    = WAIT_END;
        if (frame_sync) pend_d = 1'b1;
`ifdef RD_TIMEOUT_EN
        tmo_cnt_d = TMO_W'(1);
`endif
      end

      WAIT_END: begin
        if (rd_data_valid) word_cnt_d = sat_inc_wc(word_cnt_q);
        if (frame_sync) pend_d = 1'b1;
        if (user_rd_end) begin
          busy_d = 1'b0;
          pend_d = 1'b0;
          if (word_total != BURST_CNT) len_err_d = 1'b1;
          if (pend_q || (frame_sync && !last_burst)) begin
            resync_cnt_d = sat_inc8(resync_cnt_q);
            take_bank    = 1'b1;
            state_d      = CHECK;
          end else if (frame_sync) begin
            // Sync coinciding with the end of the last burst is an ordinary
            // frame start.
            take_bank = 1'b1;
            state_d   = CHECK;
          end else if (last_burst) begin
            state_d = WAIT_SYNC;
          end else begin
            burst_idx_d = burst_idx_q + 1'b1;
            state_d     = CHECK;
          end
        end
`ifdef RD_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          pend_d        = 1'b0;
          state_d       = WAIT_SYNC;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase

    if (take_bank) begin
      burst_idx_d = '0;
      new_frame_d = 1'b0;
      if (sel_new) rd_bank_d = sel_bank;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_bank_q <= 1'b0;
      new_frame_q  <= 1'b0;
      burst_idx_q  <= '0;
      rd_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      len_err_q    <= 1'b0;
      resync_cnt_q <= '0;
      word_cnt_q   <= '0;
      pend_q       <= 1'b0;
      fifo_low_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_bank_q <= ready_bank_d;
      new_frame_q  <= new_frame_d;
      burst_idx_q  <= burst_idx_d;
      rd_bank_q    <= rd_bank_d;
      rd_addr_q    <= rd_addr_d;
      rd_start_q   <= rd_start_d;
      busy_q       <= busy_d;
      len_err_q    <= len_err_d;
      resync_cnt_q <= resync_cnt_d;
      word_cnt_q   <= word_cnt_d;
      pend_q       <= pend_d;
      // Fill-level compare is registered, so a request follows a drop below
      // the watermark by two cycles.
      fifo_low_q   <= ({1'b0, fifo_wrcount} <= LOW_WM_V);
    end
  end

`ifdef RD_TIMEOUT_EN
  always_ff @(posedge sclk) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign rd_start   = rd_start_q;
  assign rd_addr    = rd_addr_q;
  assign rd_len     = 8'(BURST_LEN);
  assign rd_bank    = rd_bank_q;
  assign busy       = busy_q;
  assign len_err    = len_err_q;
  assign resync_cnt = resync_cnt_q;

endmodule

// File: tb/tb_hdmi_rd_sched.sv
module tb_hdmi_rd_sched;

  localparam int ADDR_W = 28;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0100_0000;

  logic              sclk;
  logic              rst;
  logic              enable;
  logic              frame_sync;
  logic              wr_frame_done;
  logic              wr_bank;
  logic [9:0]        fifo_wrcount;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              user_rd_end;
  logic              rd_data_valid;
  logic              rd_bank;
  logic              busy;
  logic              len_err;
  logic [7:0]        resync_cnt;
  logic              timeout_err;

  int tests_run;
  int tests_failed;

  hdmi_rd_sched #(
    .ADDR_W       (ADDR_W),
    .BURST_LEN    (64),
    .ADDR_INC     (512),
    .FRAME_BURSTS (4),
    .BANK_BASE0   (28'h000_0000),
    .BANK_BASE1   (28'h100_0000),
    .FIFO_AW      (10),
    .LOW_WM       (256),
    .TIMEOUT      (16)
  ) dut (
    .sclk          (sclk),
    .rst           (rst),
    .enable        (enable),
    .frame_sync    (frame_sync),
    .wr_frame_done (wr_frame_done),
    .wr_bank       (wr_bank),
    .fifo_wrcount  (fifo_wrcount),
    .rd_start      (rd_start),
    .rd_addr       (rd_addr),
    .rd_len        (rd_len),
    .user_rd_end   (user_rd_end),
    .rd_data_valid (rd_data_valid),
    .rd_bank       (rd_bank),
    .busy          (busy),
    .len_err       (len_err),
    .resync_cnt    (resync_cnt),
    .timeout_err   (timeout_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  // Advance until rd_start is seen (bounded), then check the burst address.
  task automatic wait_start(input string tag, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (rd_start !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, {31'd0, rd_start}, 32'd1);
    check({tag, "_addr"}, {4'd0, rd_addr}, exp_addr);
  endtask

  // Called in the REQ cycle; returns nvalid words and user_rd_end.
  // With overlap set, the last valid shares the cycle with user_rd_end.
  task automatic do_burst(input int nvalid, input bit overlap);
    tick();
    for (int i = 0; i < nvalid - (overlap ? 1 : 0); i++) begin
      rd_data_valid = 1'b1;
      tick();
    end
    rd_data_valid = overlap ? 1'b1 : 1'b0;
    user_rd_end   = 1'b1;
    tick();
    user_rd_end   = 1'b0;
    rd_data_valid = 1'b0;
  endtask

  task automatic count_starts(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (rd_start === 1'b1) seen++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    enable        = 1'b0;
    frame_sync    = 1'b0;
    wr_frame_done = 1'b0;
    wr_bank       = 1'b0;
    fifo_wrcount  = 10'd100;
    user_rd_end   = 1'b0;
    rd_data_valid = 1'b0;
    tick(3);

    check("rst_rd_start", {31'd0, rd_start}, 32'd0);
    check("rst_rd_addr", {4'd0, rd_addr}, 32'd0);
    check("rst_rd_len", {24'd0, rd_len}, 32'd64);
    check("rst_rd_bank", {31'd0, rd_bank}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_len_err", {31'd0, len_err}, 32'd0);
    check("rst_resync", {24'd0, resync_cnt}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);

    // Test 1: writer finishes bank 1, frame starts on bank 1.
    rst    = 1'b0;
    enable = 1'b1;
    tick();
    wr_frame_done = 1'b1;
    wr_bank       = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    pulse_sync();
    wait_start("t1_b0", B1);
    check("t1_bank", {31'd0, rd_bank}, 32'd1);
    tick();
    check("t1_busy_hi", {31'd0, busy}, 32'd1);
    check("t1_start_pulse", {31'd0, rd_start}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      rd_data_valid = 1'b1;
      tick();
    end
    rd_data_valid = 1'b0;
    user_rd_end   = 1'b1;
    tick();
    user_rd_end   = 1'b0;
    check("t1_busy_lo", {31'd0, busy}, 32'd0);
    check("t1_len_err", {31'd0, len_err}, 32'd0);
    wait_start("t1_b1", B1 + 32'd512);

    // Test 2: fill level above the watermark holds requests off.
    fifo_wrcount = 10'd300;
    do_burst(64, 1'b1);
    check("t2_len_overlap", {31'd0, len_err}, 32'd0);
    count_starts(6, seen);
    check("t2_no_start", seen, 32'd0);
    fifo_wrcount = 10'd256;
    tick();
    check("t2_start_1cyc", {31'd0, rd_start}, 32'd0);
    tick();
    check("t2_start_2cyc", {31'd0, rd_start}, 32'd1);
    check("t2_addr", {4'd0, rd_addr}, B1 + 32'd1024);

    // Test 3: end of frame waits for sync, then repeats the bank.
    fifo_wrcount = 10'd100;
    do_burst(64, 1'b0);
    wait_start("t3_b3", B1 + 32'd1536);
    do_burst(64, 1'b0);
    count_starts(10, seen);
    check("t3_wait_sync", seen, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd0);
    pulse_sync();
    wait_start("t3_repeat", B1);
    check("t3_bank", {31'd0, rd_bank}, 32'd1);

    // Test 4: sync during a burst is deferred until the burst ends.
    do_burst(64, 1'b0);
    wait_start("t4_b1", B1 + 32'd512);
    tick();
    rd_data_valid = 1'b1;
    tick(10);
    wr_frame_done = 1'b1;
    wr_bank       = 1'b0;
    tick();
    wr_frame_done = 1'b0;
    frame_sync    = 1'b1;
    tick();
    frame_sync    = 1'b0;
    check("t4_busy_held", {31'd0, busy}, 32'd1);
    check("t4_resync_pre", {24'd0, resync_cnt}, 32'd0);
    tick(52);
    rd_data_valid = 1'b0;
    user_rd_end   = 1'b1;
    tick();
    user_rd_end   = 1'b0;
    check("t4_resync", {24'd0, resync_cnt}, 32'd1);
    check("t4_bank", {31'd0, rd_bank}, 32'd0);
    check("t4_len_err", {31'd0, len_err}, 32'd0);
    wait_start("t4_restart", B0);

    // Test 5: short burst sets a sticky length error; schedule continues.
    do_burst(63, 1'b0);
    check("t5_len_err", {31'd0, len_err}, 32'd1);
    wait_start("t5_next", B0 + 32'd512);
    do_burst(64, 1'b0);
    check("t5_sticky", {31'd0, len_err}, 32'd1);
    wait_start("t5_b2", B0 + 32'd1024);

    // Mid-frame sync while parked in CHECK restarts immediately.
    fifo_wrcount = 10'd300;
    do_burst(64, 1'b0);
    tick(2);
    pulse_sync();
    check("chk_resync", {24'd0, resync_cnt}, 32'd2);
    fifo_wrcount = 10'd100;
    wait_start("chk_restart", B0);

    // Sync with the last burst's end, plus a same-cycle new bank.
    do_burst(64, 1'b0);
    wait_start("fe_b1", B0 + 32'd512);
    do_burst(64, 1'b0);
    wait_start("fe_b2", B0 + 32'd1024);
    do_burst(64, 1'b0);
    wait_start("fe_b3", B0 + 32'd1536);
    tick();
    rd_data_valid = 1'b1;
    tick(64);
    rd_data_valid = 1'b0;
    user_rd_end   = 1'b1;
    frame_sync    = 1'b1;
    wr_frame_done = 1'b1;
    wr_bank       = 1'b1;
    tick();
    user_rd_end   = 1'b0;
    frame_sync    = 1'b0;
    wr_frame_done = 1'b0;
    check("fe_resync_same", {24'd0, resync_cnt}, 32'd2);
    check("fe_bank", {31'd0, rd_bank}, 32'd1);
    wait_start("fe_restart", B1);

    // Reset in the middle of a burst.
    tick();
    rd_data_valid = 1'b1;
    tick(5);
    rst = 1'b1;
    tick();
    rd_data_valid = 1'b0;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_len_err", {31'd0, len_err}, 32'd0);
    check("mrst_resync", {24'd0, resync_cnt}, 32'd0);
    check("mrst_bank", {31'd0, rd_bank}, 32'd0);
    check("mrst_addr", {4'd0, rd_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // Test 6: user_rd_end withheld.
    pulse_sync();
    wait_start("t6_start", B0);
    tick(15);
    check("t6_busy_15", {31'd0, busy}, 32'd1);
    check("t6_tmo_15", {31'd0, timeout_err}, 32'd0);
    tick();
`ifdef RD_TIMEOUT_EN
    check("t6_tmo_16", {31'd0, timeout_err}, 32'd1);
    check("t6_busy_16", {31'd0, busy}, 32'd0);
    pulse_sync();
    wait_start("t6_restart", B0);
`else
    check("t6_tmo_16", {31'd0, timeout_err}, 32'd0);
    check("t6_busy_16", {31'd0, busy}, 32'd1);
    rd_data_valid = 1'b1;
    tick(64);
    rd_data_valid = 1'b0;
    user_rd_end   = 1'b1;
    tick();
    user_rd_end   = 1'b0;
    check("t6_len_err", {31'd0, len_err}, 32'd0);
    wait_start("t6_next", B0 + 32'd512);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
